hold_press_judge: RTL and testbench

Parametrised multi-channel press/hold detector for the car's button and switch inputs, power key included. Each channel synchronises a raw level and counts consecutive high cycles on a saturating counter. It reports a hold level, a one-cycle long-press pulse, a one-cycle short-press pulse on release, and a latched output. The latched output follows the hold level or toggles on each long press, selected per channel. It sits between the board inputs and the top-level control FSM.

---
 rtl/hold_judge_pkg.sv | 22 ++
 rtl/hold_judge_chan.sv | 85 ++++++++
 rtl/hold_press_judge.sv | 54 +++++
 tb/tb_hold_press_judge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hold_judge_pkg.sv
// Shared constants, defaults and helpers for the hold_press_judge channel bank.
package hold_judge_pkg;

    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    localparam int DEF_CH          = 4;
    localparam int DEF_HOLD_CYCLES = 50;
    localparam int DEF_SHORT_MIN   = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hold_judge_chan.sv
// One press/hold channel: input synchroniser, saturating high-time counter
// and registered held / long / short / latched outputs.
module hold_judge_chan
    import hold_judge_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SHORT_MIN   = DEF_SHORT_MIN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic en,
    input  logic mode,
    output logic held,
    output logic long_pulse,
    output logic short_pulse,
    output logic latched
);

    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MIN);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   held_nxt;
    logic                   long_nxt;
    logic                   short_nxt;
    logic                   latched_nxt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    always_comb begin
        cnt_nxt     = '0;
        held_nxt    = 1'b0;
        long_nxt    = 1'b0;
        short_nxt   = 1'b0;
        latched_nxt = latched;
        if (en && s) begin
            cnt_nxt = (cnt == HOLD_C) ? cnt : cnt + CNT_W'(1);
        end
        held_nxt  = en && s && (cnt == HOLD_C);
        // The pulse marks the rising edge of held, so a saturated hold never repeats it.
        long_nxt  = held_nxt && !held;
        short_nxt = en && !s && (cnt >= SHORT_C) && (cnt < HOLD_C);
        if (en) begin
            unique case (mode)
                MODE_LEVEL:  latched_nxt = held_nxt;
                MODE_TOGGLE: latched_nxt = latched ^ long_nxt;
                default:     latched_nxt = latched;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            held        <= 1'b0;
            long_pulse  <= 1'b0;
            short_pulse <= 1'b0;
            latched     <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            held        <= held_nxt;
            long_pulse  <= long_nxt;
            short_pulse <= short_nxt;
            latched     <= latched_nxt;
        end
    end

endmodule

// File: rtl/hold_press_judge.sv
// Multi-channel press/hold detector between the board inputs and the control FSM.
module hold_press_judge
    import hold_judge_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SHORT_MIN   = DEF_SHORT_MIN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] raw_in,
    input  logic [CH-1:0] en,
    input  logic [CH-1:0] mode_toggle,
    output logic [CH-1:0] held,
    output logic [CH-1:0] long_pulse,
    output logic [CH-1:0] short_pulse,
    output logic [CH-1:0] latched
);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("hold_press_judge: HOLD_CYCLES must be >= 2");
    end
    if (SHORT_MIN < 1 || SHORT_MIN >= HOLD_CYCLES) begin : g_bad_short
        $error("hold_press_judge: SHORT_MIN must satisfy 1 <= SHORT_MIN < HOLD_CYCLES");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("hold_press_judge: SYNC_STAGES must be >= 1");
    end
    if (CNT_W < clog2(HOLD_CYCLES + 1)) begin : g_bad_cnt
        $error("hold_press_judge: CNT_W too narrow for HOLD_CYCLES");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        hold_judge_chan #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .SHORT_MIN   (SHORT_MIN),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (raw_in[i]),
            .en          (en[i]),
            .mode        (mode_toggle[i]),
            .held        (held[i]),
            .long_pulse  (long_pulse[i]),
            .short_pulse (short_pulse[i]),
            .latched     (latched[i])
        );
    end

endmodule

// File: tb/tb_hold_press_judge.sv
// Directed bench for hold_press_judge with default parameters.
module tb_hold_press_judge;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_in;
    logic [3:0] en;
    logic [3:0] mode_toggle;
    logic [3:0] held;
    logic [3:0] long_pulse;
    logic [3:0] short_pulse;
    logic [3:0] latched;

    int n_checks;
    int n_fail;

    logic [3:0] acc_long;
    logic [3:0] acc_short;
    logic [3:0] acc_held;
    int         long_cnt [4];
    int         short_cnt[4];

    hold_press_judge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .en          (en),
        .mode_toggle (mode_toggle),
        .held        (held),
        .long_pulse  (long_pulse),
        .short_pulse (short_pulse),
        .latched     (latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        acc_long  = '0;
        acc_short = '0;
        acc_held  = '0;
        for (int i = 0; i < 4; i++) begin
            long_cnt[i]  = 0;
            short_cnt[i] = 0;
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            acc_long  = acc_long  | long_pulse;
            acc_short = acc_short | short_pulse;
            acc_held  = acc_held  | held;
            for (int i = 0; i < 4; i++) begin
                long_cnt[i]  += int'(long_pulse[i]);
                short_cnt[i] += int'(short_pulse[i]);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        raw_in      = 4'($urandom);
        en          = 4'($urandom);
        mode_toggle = 4'($urandom);
        clear_acc();
        step(4);
        check_eq("rst_held",  32'(held),        32'h0);
        check_eq("rst_long",  32'(long_pulse),  32'h0);
        check_eq("rst_short", 32'(short_pulse), 32'h0);
        check_eq("rst_latch", 32'(latched),     32'h0);

        raw_in      = 4'h0;
        en          = 4'hF;
        mode_toggle = 4'h0;
        rst_n       = 1'b1;
        step(4);
        check_eq("post_rst_all", 32'({held, long_pulse, short_pulse, latched}), 32'h0);

        // Ch0 long press in level mode, 60 edges high
        clear_acc();
        raw_in = 4'b0001;
        step(52);
        check_eq("A_held_e52", 32'(held[0]), 32'h0);
        check_eq("A_long_e52", 32'(acc_long[0]), 32'h0);
        step(1);
        check_eq("A_held_e53",  32'(held[0]),       32'h1);
        check_eq("A_long_e53",  32'(long_pulse[0]), 32'h1);
        check_eq("A_latch_e53", 32'(latched[0]),    32'h1);
        step(1);
        check_eq("A_long_e54", 32'(long_pulse[0]), 32'h0);
        step(6);
        raw_in = 4'b0000;
        step(2);
        check_eq("A_held_e62", 32'(held[0]), 32'h1);
        step(1);
        check_eq("A_held_e63",  32'(held[0]),    32'h0);
        check_eq("A_latch_e63", 32'(latched[0]), 32'h0);
        step(2);
        check_eq("A_long_count", 32'(long_cnt[0]),  32'd1);
        check_eq("A_no_short",   32'(acc_short[0]), 32'h0);

        // Ch1 short press of 10 edges, ch2 glitch of 2 edges
        clear_acc();
        raw_in = 4'b0110;
        step(2);
        raw_in = 4'b0010;
        step(8);
        raw_in = 4'b0000;
        step(2);
        check_eq("B_short_e12", 32'(short_pulse[1]), 32'h0);
        step(1);
        check_eq("B_short_e13", 32'(short_pulse[1]), 32'h1);
        check_eq("B_held_e13",  32'(held[1]),        32'h0);
        step(1);
        check_eq("B_short_e14", 32'(short_pulse[1]), 32'h0);
        step(5);
        check_eq("B_short_count1", 32'(short_cnt[1]), 32'd1);
        check_eq("B_ch2_quiet", 32'({acc_long[2], acc_short[2], acc_held[2], latched[2]}), 32'h0);
        check_eq("B_ch1_nolong", 32'({acc_long[1], acc_held[1]}), 32'h0);

        // Ch3 toggle mode: two long presses then a 300-edge hold
        clear_acc();
        mode_toggle = 4'b1000;
        raw_in = 4'b1000;
        step(52);
        check_eq("C_latch_e52", 32'(latched[3]), 32'h0);
        step(1);
        check_eq("C_latch_e53", 32'(latched[3]),    32'h1);
        check_eq("C_long_e53",  32'(long_pulse[3]), 32'h1);
        step(7);
        raw_in = 4'b0000;
        step(5);
        check_eq("C_latch_rel1", 32'(latched[3]), 32'h1);
        check_eq("C_held_rel1",  32'(held[3]),    32'h0);
        raw_in = 4'b1000;
        step(53);
        check_eq("C_latch_p2", 32'(latched[3]), 32'h0);
        step(7);
        raw_in = 4'b0000;
        step(5);
        check_eq("C_latch_rel2", 32'(latched[3]),  32'h0);
        check_eq("C_long_count", 32'(long_cnt[3]), 32'd2);
        clear_acc();
        raw_in = 4'b1000;
        step(300);
        check_eq("C_sat_long_count", 32'(long_cnt[3]), 32'd1);
        check_eq("C_sat_held",       32'(held[3]),     32'h1);
        check_eq("C_sat_latch",      32'(latched[3]),  32'h1);
        raw_in = 4'b0000;
        step(5);
        check_eq("C_sat_no_short", 32'(acc_short[3]), 32'h0);
        check_eq("C_sat_latch_rel", 32'(latched[3]), 32'h1);
        mode_toggle = 4'b0000;
        step(1);
        check_eq("C_mode_to_level", 32'(latched[3]), 32'h0);

        // Ch0 enable dropped mid-press, then re-enabled while pressed
        mode_toggle = 4'b0001;
        raw_in = 4'b0001;
        step(53);
        check_eq("D_latch_set", 32'(latched[0]), 32'h1);
        step(7);
        raw_in = 4'b0000;
        step(5);
        clear_acc();
        raw_in = 4'b0001;
        step(32);
        en = 4'b1110;
        step(20);
        check_eq("D_dis_quiet", 32'({acc_long[0], acc_short[0], acc_held[0]}), 32'h0);
        check_eq("D_dis_latch", 32'(latched[0]), 32'h1);
        en = 4'b1111;
        step(50);
        check_eq("D_reen_held_50", 32'(held[0]), 32'h0);
        step(1);
        check_eq("D_reen_held_51",  32'(held[0]),       32'h1);
        check_eq("D_reen_long_51",  32'(long_pulse[0]), 32'h1);
        check_eq("D_reen_latch_51", 32'(latched[0]),    32'h0);
        raw_in = 4'b0000;
        step(5);

        // All channels, level mode, staggered starts
        mode_toggle = 4'b0000;
        step(2);
        raw_in = 4'b0001;
        step(1);
        raw_in = 4'b0011;
        step(1);
        raw_in = 4'b0111;
        step(1);
        raw_in = 4'b1111;
        step(49);
        check_eq("E_long_e52", 32'(long_pulse), 32'h0);
        step(1);
        check_eq("E_long_e53", 32'(long_pulse), 32'h1);
        step(1);
        check_eq("E_long_e54", 32'(long_pulse), 32'h2);
        step(1);
        check_eq("E_long_e55", 32'(long_pulse), 32'h4);
        step(1);
        check_eq("E_long_e56", 32'(long_pulse), 32'h8);
        check_eq("E_held_e56", 32'(held),       32'hF);
        step(1);
        check_eq("E_long_e57", 32'(long_pulse), 32'h0);
        raw_in = 4'b0000;
        step(5);
        check_eq("E_released", 32'({held, latched}), 32'h0);

        // Asynchronous reset mid-press
        raw_in = 4'b0001;
        step(23);
        raw_in = 4'b0011;
        step(32);
        check_eq("F_held_pre", 32'(held[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("F_rst_now", 32'({held, long_pulse, short_pulse, latched}), 32'h0);
        raw_in = 4'b0000;
        step(2);
        rst_n = 1'b1;
        clear_acc();
        step(60);
        check_eq("F_no_pulse", 32'({acc_long, acc_short, acc_held, latched}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
